// File: rtl/text_ram_arbiter.sv
// Character RAM arbiter for the text-mode display. Each visible cell gets one
// guaranteed read slot; host accesses and the screen-clear engine share the rest.
module text_ram_arbiter #(
    parameter int COLS        = 80,
    parameter int ROWS        = 30,
    parameter int CELL_W_LOG2 = 3,
    parameter int CELL_H_LOG2 = 4,
    parameter int H_VISIBLE   = 640,
    parameter int V_VISIBLE   = 480
) (
    input  logic        i_Clk,
    input  logic        i_Reset_L,
    input  logic [11:0] i_X,
    input  logic [11:0] i_Y,
    input  logic        i_Host_Req,
    input  logic        i_Host_We,
    input  logic [11:0] i_Host_Addr,
    input  logic [7:0]  i_Host_Wdata,
    output logic        o_Host_Ack,
    output logic [7:0]  o_Host_Rdata,
    input  logic        i_Clear,
    input  logic [7:0]  i_Clear_Char,
    output logic        o_Busy,
    output logic [11:0] o_Ram_Addr,
    output logic        o_Ram_We,
    output logic [7:0]  o_Ram_Wdata,
    input  logic [7:0]  i_Ram_Rdata,
    output logic [7:0]  o_Char_Code,
    output logic [3:0]  o_Char_Row,
    output logic        o_Char_Valid
);

    localparam logic [11:0] DEPTH     = 12'(COLS * ROWS);
    localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]  state;
    logic [11:0] clr_ptr;
    logic [7:0]  clr_char;

    logic        host_ack_q;
    logic        host_rd_q;
    logic        disp_q;
    logic [3:0]  disp_row_q;

    logic        display_slot;
    logic [11:0] disp_addr;
    logic        host_in_range;
    logic        clear_start;
    logic        host_issue;
    logic        clear_write;

    // NOTE: every signal written here is assigned on every pass, so no latch can be inferred.
    always_comb begin
        display_slot  = (i_X < 12'(H_VISIBLE)) && (i_Y < 12'(V_VISIBLE)) &&
                        (i_X[CELL_W_LOG2-1:0] == '0);
        disp_addr     = 12'((i_Y >> CELL_H_LOG2) * COLS) + (i_X >> CELL_W_LOG2);
        host_in_range = (i_Host_Addr < DEPTH);
        clear_start   = (state == ST_IDLE) && i_Clear;
        // A clear request arriving with a host request wins; the host simply keeps waiting.
        host_issue    = (state == ST_IDLE) && !display_slot && i_Host_Req && !i_Clear;
        clear_write   = (state == ST_CLEAR) && !display_slot;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Reset_L) begin
        if (!i_Reset_L) begin
            o_Ram_Addr  <= '0;
            o_Ram_We    <= 1'b0;
            o_Ram_Wdata <= '0;
        end else begin
            o_Ram_We <= 1'b0;
            if (display_slot) begin
                o_Ram_Addr <= disp_addr;
            end else if (clear_write) begin
                o_Ram_Addr  <= clr_ptr;
                o_Ram_We    <= 1'b1;
                o_Ram_Wdata <= clr_char;
            end else if (host_issue && host_in_range) begin
                o_Ram_Addr <= i_Host_Addr;
                o_Ram_We   <= i_Host_We;
                if (i_Host_We) begin
                    o_Ram_Wdata <= i_Host_Wdata;
                end
            end
        end
    end

    // Out-of-range host accesses are acknowledged without touching the RAM.
    always_ff @(posedge i_Clk or negedge i_Reset_L) begin
        if (!i_Reset_L) begin
            host_ack_q <= 1'b0;
            host_rd_q  <= 1'b0;
        end else begin
            host_ack_q <= host_issue;
            host_rd_q  <= host_issue && !i_Host_We && host_in_range;
        end
    end

    assign o_Host_Ack   = host_ack_q;
    assign o_Host_Rdata = host_rd_q ? i_Ram_Rdata : 8'h00;

    // Display pipeline: slot at t, RAM data at t+1, registered cell at t+2.
    always_ff @(posedge i_Clk or negedge i_Reset_L) begin
        if (!i_Reset_L) begin
            disp_q       <= 1'b0;
            disp_row_q   <= '0;
            o_Char_Code  <= '0;
            o_Char_Row   <= '0;
            o_Char_Valid <= 1'b0;
        end else begin
            disp_q       <= display_slot;
            o_Char_Valid <= disp_q;
            if (display_slot) begin
                disp_row_q <= i_Y[3:0];
            end
            if (disp_q) begin
                o_Char_Code <= i_Ram_Rdata;
                o_Char_Row  <= disp_row_q;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_L) begin
        if (!i_Reset_L) begin
            state    <= ST_IDLE;
            clr_ptr  <= '0;
            clr_char <= '0;
        end else if (state == ST_IDLE) begin
            if (clear_start) begin
                state    <= ST_CLEAR;
                clr_ptr  <= '0;
                clr_char <= i_Clear_Char;
            end
        end else if (clear_write) begin
            clr_ptr <= clr_ptr + 12'd1;
            if (clr_ptr == LAST_ADDR) begin
                state <= ST_IDLE;
            end
        end
    end

    assign o_Busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Self-checking bench for text_ram_arbiter: table-driven display scan with a
// scoreboard for fetched cells, plus hand sequences for host, clear and reset.
module tb_text_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] x, y;
    logic        host_req, host_we;
    logic [11:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic        clear;
    logic [7:0]  clear_char;
    logic        busy;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  char_code;
    logic [3:0]  char_row;
    logic        char_valid;

    int total = 0;
    int bad   = 0;

    text_ram_arbiter dut (
        .i_Clk        (clk),
        .i_Reset_L    (rst_n),
        .i_X          (x),
        .i_Y          (y),
        .i_Host_Req   (host_req),
        .i_Host_We    (host_we),
        .i_Host_Addr  (host_addr),
        .i_Host_Wdata (host_wdata),
        .o_Host_Ack   (host_ack),
        .o_Host_Rdata (host_rdata),
        .i_Clear      (clear),
        .i_Clear_Char (clear_char),
        .o_Busy       (busy),
        .o_Ram_Addr   (ram_addr),
        .o_Ram_We     (ram_we),
        .o_Ram_Wdata  (ram_wdata),
        .i_Ram_Rdata  (ram_rdata),
        .o_Char_Code  (char_code),
        .o_Char_Row   (char_row),
        .o_Char_Valid (char_valid)
    );

    always #5 clk = ~clk;

    // Background pattern for never-written cells.
    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'hA5;
    endfunction

    // RAM model: read data follows the registered address (one cycle after issue).
    logic [7:0] mem     [0:4095];
    logic       written [0:4095];
    int         wcnt    [0:4095];
    int         oor_writes;
    logic       mem_init, cnt_clr;

    assign ram_rdata = written[ram_addr] ? mem[ram_addr] : pat(ram_addr);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
            oor_writes <= 0;
        end
        if (cnt_clr) begin
            for (int i = 0; i < 4096; i++) wcnt[i] <= 0;
        end
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            written[ram_addr] <= 1'b1;
            wcnt[ram_addr]    <= wcnt[ram_addr] + 1;
            if (ram_addr >= 12'd2400) oor_writes <= oor_writes + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] code;
        logic [3:0] row;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && char_valid) begin
            if (exp_q.size() == 0) begin
                check("char_unexpected", 32'(char_valid), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("char_code", 32'(char_code), 32'(mon_e.code));
                check("char_row", 32'(char_row), 32'(mon_e.row));
            end
        end
    end

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic        slot;
        logic [11:0] addr;
        logic [3:0]  row;
    } vec_t;
    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int busy_cycles, ack_seen, bad_addr;
        logic found;

        vecs[0]  = '{12'd0,    12'd17,  1'b1, 12'd80,   4'd1};
        vecs[1]  = '{12'd8,    12'd17,  1'b1, 12'd81,   4'd1};
        vecs[2]  = '{12'd9,    12'd17,  1'b0, 12'd0,    4'd0};
        vecs[3]  = '{12'd632,  12'd479, 1'b1, 12'd2399, 4'd15};
        vecs[4]  = '{12'd640,  12'd0,   1'b0, 12'd0,    4'd0};
        vecs[5]  = '{12'd0,    12'd480, 1'b0, 12'd0,    4'd0};
        vecs[6]  = '{12'd16,   12'd0,   1'b1, 12'd2,    4'd0};
        vecs[7]  = '{12'd7,    12'd0,   1'b0, 12'd0,    4'd0};
        vecs[8]  = '{12'd320,  12'd250, 1'b1, 12'd1240, 4'd10};
        vecs[9]  = '{12'd639,  12'd479, 1'b0, 12'd0,    4'd0};
        vecs[10] = '{12'd2000, 12'd100, 1'b0, 12'd0,    4'd0};

        // Reset held with an active slot and a host request on the inputs.
        rst_n = 1'b0; mem_init = 1'b1; cnt_clr = 1'b1;
        x = 12'd0; y = 12'd0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'd3; host_wdata = 8'h11;
        clear = 1'b0; clear_char = 8'h00;
        tick(); tick(); tick();
        mem_init = 1'b0; cnt_clr = 1'b0;
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_char", 32'({char_code, char_row, char_valid}), 32'd0);

        // Release in blanking: nothing should happen.
        host_req = 1'b0; x = 12'd700; y = 12'd500;
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("idle_ram_we", 32'(ram_we), 32'd0);
        check("idle_ram_addr", 32'(ram_addr), 32'd0);
        check("idle_valid", 32'(char_valid), 32'd0);
        check("idle_ack", 32'(host_ack), 32'd0);

        // Display scan table.
        for (int i = 0; i < 11; i++) begin
            x = vecs[i].x; y = vecs[i].y;
            if (vecs[i].slot) exp_q.push_back('{pat(vecs[i].addr), vecs[i].row});
            tick();
            check("scan_we", 32'(ram_we), 32'd0);
            if (vecs[i].slot) check("scan_addr", 32'(ram_addr), 32'(vecs[i].addr));
        end
        x = 12'd700; y = 12'd500;
        tick(); tick(); tick();
        check("scan_drained", 32'(exp_q.size()), 32'd0);

        // Host write colliding with a display slot is deferred one cycle.
        x = 12'd8; y = 12'd17;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'd5; host_wdata = 8'h41;
        exp_q.push_back('{pat(12'd81), 4'd1});
        tick();
        check("coll_no_ack", 32'(host_ack), 32'd0);
        check("coll_disp_addr", 32'(ram_addr), 32'd81);
        check("coll_disp_we", 32'(ram_we), 32'd0);
        x = 12'd9;
        tick();
        check("coll_wr", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 12'd5, 8'h41}));
        check("coll_ack", 32'(host_ack), 32'd1);
        x = 12'd10; host_req = 1'b0;
        tick();
        check("coll_ack_pulse", 32'(host_ack), 32'd0);

        // Readback, then a back-to-back read held through the ack cycle.
        x = 12'd11; host_req = 1'b1; host_we = 1'b0; host_addr = 12'd5;
        tick();
        check("rd5_ack", 32'(host_ack), 32'd1);
        check("rd5_data", 32'(host_rdata), 32'h41);
        x = 12'd12; host_addr = 12'd6;
        tick();
        check("rd6_ack", 32'(host_ack), 32'd1);
        check("rd6_data", 32'(host_rdata), 32'(pat(12'd6)));
        x = 12'd13; host_req = 1'b0;
        tick();
        check("rd_ack_drop", 32'(host_ack), 32'd0);

        // Out-of-range host accesses.
        x = 12'd700; y = 12'd500;
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'd2400; host_wdata = 8'h77;
        tick();
        check("oor_wr_ack", 32'(host_ack), 32'd1);
        check("oor_wr_we", 32'(ram_we), 32'd0);
        host_we = 1'b0;
        tick();
        check("oor_rd_ack", 32'(host_ack), 32'd1);
        check("oor_rd_data", 32'(host_rdata), 32'd0);
        host_req = 1'b0;
        tick();

        // Full clear in blanking with a simultaneous host read that must wait.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        clear = 1'b1; clear_char = 8'h20;
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'd10;
        tick();
        clear = 1'b0;
        check("clr_busy_rise", 32'(busy), 32'd1);
        check("clr_host_wait", 32'(host_ack), 32'd0);
        busy_cycles = 1; ack_seen = 0;
        for (int i = 0; i < 3000 && busy; i++) begin
            if (busy_cycles == 100) begin
                clear = 1'b1; clear_char = 8'h99;
            end else begin
                clear = 1'b0;
            end
            tick();
            if (host_ack) ack_seen++;
            if (busy) busy_cycles++;
        end
        clear = 1'b0;
        check("clr_busy_cycles", 32'(busy_cycles), 32'd2400);
        check("clr_no_ack_while_busy", 32'(ack_seen), 32'd0);
        tick();
        check("clr_host_ack", 32'(host_ack), 32'd1);
        check("clr_host_rdata", 32'(host_rdata), 32'h20);
        host_req = 1'b0;
        tick();
        bad_addr = 0;
        for (int a = 0; a < 2400; a++) begin
            if (wcnt[a] != 1 || mem[a] !== 8'h20) bad_addr++;
        end
        check("clr_all_once", 32'(bad_addr), 32'd0);

        // Reset in the middle of a clear.
        clear = 1'b1; clear_char = 8'h33;
        tick();
        clear = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (ram_we && ram_addr == 12'd1000) found = 1'b1;
        end
        check("midclr_reach_1000", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midclr_busy", 32'(busy), 32'd0);
        check("midclr_we", 32'(ram_we), 32'd0);
        check("midclr_addr", 32'(ram_addr), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midclr_idle", 32'({busy, ram_we}), 32'd0);

        // Restarted clear begins at address 0 and skips a display slot.
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        clear = 1'b1; clear_char = 8'h44;
        tick();
        clear = 1'b0;
        check("reclr_busy", 32'(busy), 32'd1);
        tick();
        check("reclr_first", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 12'd0, 8'h44}));
        x = 12'd8; y = 12'd0;
        exp_q.push_back('{8'h33, 4'd0});
        tick();
        check("reclr_slot_read", 32'({ram_we, ram_addr}), 32'({1'b0, 12'd1}));
        x = 12'd700; y = 12'd500;
        tick();
        check("reclr_resume", 32'({ram_we, ram_addr, ram_wdata}), 32'({1'b1, 12'd1, 8'h44}));
        for (int i = 0; i < 3000 && busy; i++) tick();
        check("reclr_done", 32'(busy), 32'd0);
        tick();
        bad_addr = 0;
        for (int a = 0; a < 2400; a++) begin
            if (wcnt[a] != 1 || mem[a] !== 8'h44) bad_addr++;
        end
        check("reclr_all_once", 32'(bad_addr), 32'd0);

        tick(); tick();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("no_oor_writes", 32'(oor_writes), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/text_ram_arbiter.md
# text_ram_arbiter

Arbitrates the single-port character (text) RAM of the text-mode display between the scan-out fetch path and a host port (e.g. UART command decoder), and also runs a screen-clear engine. Sits between the VGA timing generator (which supplies lead-adjusted X/Y) and the font ROM stage. Each visible 8-pixel cell gets one guaranteed display read slot. Host and clear traffic use all remaining cycles.

## Interface
- COLS, 80: character columns.
- ROWS, 30: character rows; RAM depth = COLS*ROWS = 2400.
- CELL_W_LOG2, 3: cell width 8 px.
- CELL_H_LOG2, 4: cell height 16 px.
- H_VISIBLE, 640 / V_VISIBLE, 480: visible area in pixels.

Ports:
- i_Clk  in  1  system/pixel clock; everything is on its rising edge.
- i_Reset_L  in  1  asynchronous, active-low reset.
- i_X, i_Y  in  12 each  lead-adjusted pixel coordinates from the VGA timing generator.
- i_Host_Req  in  1  host access request; held until o_Host_Ack.
- i_Host_We  in  1  1 = write, 0 = read.
- i_Host_Addr  in  12  cell address, row*COLS+col.
- i_Host_Wdata  in  8  write character.
- o_Host_Ack  out  1  one-cycle completion pulse.
- o_Host_Rdata  out  8  read data, valid when o_Host_Ack=1.
- i_Clear  in  1  pulse; fill the RAM with i_Clear_Char.
- i_Clear_Char  in  8  fill value, sampled when i_Clear is accepted.
- o_Busy  out  1  clear in progress.
- o_Ram_Addr  out  12 / o_Ram_We  out  1 / o_Ram_Wdata  out  8  RAM port, registered.
- i_Ram_Rdata  in  8  RAM read data, 1-cycle latency.
- o_Char_Code  out  8 / o_Char_Row  out  4 / o_Char_Valid  out  1  fetched cell for the font ROM stage.

## Operation
- Display slot: a cycle where i_X<H_VISIBLE, i_Y<V_VISIBLE and i_X[2:0]==0.
  - Issue a read of (i_Y>>4)*COLS + (i_X>>3) with o_Ram_We=0.
  - The display slot has absolute priority.
- All other cycles are free slots. Blanking cycles are all free.
- States: IDLE and CLEAR.
- IDLE, free slot, i_Host_Req=1: issue the host access this cycle.
- Host completion:
  - o_Host_Ack pulses the next cycle.
  - For reads, o_Host_Rdata = i_Ram_Rdata in the ack cycle.
  - If Req is still high in the ack cycle, it is a new transaction. Maximum throughput is one per free cycle.
- Host address ≥ COLS*ROWS:
  - No RAM write is issued.
  - Still acked; read returns 0x00.
- IDLE, i_Clear=1:
  - Latch i_Clear_Char, go to CLEAR and raise o_Busy the next cycle.
  - An in-flight host access still gets its ack.
  - If i_Clear and i_Host_Req arrive together, clear wins; the host waits.
- CLEAR:
  - Each free slot writes the fill char to the clear pointer, then the pointer increments. Display slots are skipped.
  - The pointer runs 0..COLS*ROWS-1. After writing the last address, return to IDLE; o_Busy drops the cycle after that last write.
  - Host requests are stalled (no ack) during CLEAR.
  - i_Clear is ignored while in CLEAR.
- Display output: the read issued in a display slot at cycle t returns at t+1.
  - At t+2: o_Char_Code = data, o_Char_Row = i_Y[3:0] captured at t, o_Char_Valid = 1 for one cycle.
- Reset (asserted any time, including mid-clear):
  - All outputs go to 0 and state goes to IDLE. A partial clear is abandoned.
  - The pending host ack is dropped; the host must re-request.

## Timing
- Display fetch latency: 2 cycles from the slot to o_Char_Valid. The VGA timing generator's lead must cover this plus font ROM latency.
- Host latency: 1 cycle (free slot) or 2 cycles (display slot) from Req to ack in IDLE.
- Worst-case active-line host bandwidth: 7 of 8 cycles.
- Full clear duration: 2400 writes plus skipped display slots, at most 2743 cycles when started in active video.
- RAM outputs are registered. Address arithmetic is done in 12 bits; row*COLS is at most 2320.

## Test plan
- Reset: hold i_Reset_L=0 -> all outputs 0, o_Busy=0. Release -> no activity until the first slot.
- Display scan: i_X=0, i_Y=17 -> o_Ram_Addr=80, We=0. Two cycles later, Char_Valid=1 with Row=1 and Code equal to the RAM data at address 80.
- Host collision:
  - Host write at addr 5, 0x41, issued in the display-slot cycle (i_X=8) -> write issues at i_X=9, ack at i_X=10.
  - Readback -> Rdata=0x41.
- Out-of-range: host write at addr 2400 -> ack, no o_Ram_We; read at 2400 returns 0x00.
- Clear: i_Clear with char 0x20 during blanking -> o_Busy for exactly 2400 cycles, addresses 0..2399 written once each. A host request made during the clear is acked only after o_Busy=0.
- Reset mid-clear: assert i_Reset_L low at pointer=1000 -> Busy=0, IDLE. A new i_Clear restarts from address 0.
